// File: rtl/seg7_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_monitor_if                                              |
// | Description : Display-bus bundle between a seven-segment display driver   |
// |               and the seg7_monitor capture block.                          |
// |   seg_n      : active-low segments a..g (bit0 = a)                         |
// |   an_n       : active-low digit enables, one bit per position              |
// |   digits     : decoded 4-bit code per position, position i at [4i+3:4i]    |
// |   valid      : position holds a legal decode (0-9 or blank)               |
// |   upd        : one-cycle pulse per commit                                  |
// |   err        : one-cycle pulse when a commit decodes an illegal pattern    |
// |   frame_done : one-cycle pulse once every position has committed          |
// |   master     : display side (drives pins, observes results)                |
// |   slave      : monitor side                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface seg7_monitor_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   valid;
  logic                upd;
  logic                err;
  logic                frame_done;

  modport master (
    output seg_n, an_n,
    input  digits, valid, upd, err, frame_done
  );

  modport slave (
    input  seg_n, an_n,
    output digits, valid, upd, err, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_monitor                                                 |
// | Description : Samples a multiplexed, active-low seven-segment display bus, |
// |               waits for each selected digit to be stable for             |
// |               STABLE_CYCLES synchronized samples, then decodes the segment |
// |               pattern back into a 4-bit code for that position.           |
// | Ports       : clk   - system clock                                         |
// |               rst_n - asynchronous active-low reset                        |
// |               bus   - seg7_monitor_if.slave (pins in, decoded results out) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_monitor #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg7_monitor_if.slave bus
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW   = $clog2(STABLE_CYCLES + 1);

  localparam logic [CW-1:0]     c_cnt_one  = CW'(1);
  localparam logic [CW-1:0]     c_cnt_last = CW'(STABLE_CYCLES - 1);
  localparam logic [DIGITS-1:0] c_an_one   = DIGITS'(1);
  localparam logic [DIGITS-1:0] c_all_seen = '1;
  localparam logic [3:0]        c_blank    = 4'hF;
  localparam logic [3:0]        c_illegal  = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers; all-ones is the "nothing driven" state
  // --------------------------------------------------------------------------
  logic [6:0]        r_seg_s1, r_seg_s2;
  logic [DIGITS-1:0] r_an_s1,  r_an_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_an_s1  <= '1;
      r_an_s2  <= '1;
    end else begin
      r_seg_s1 <= bus.seg_n;
      r_seg_s2 <= r_seg_s1;
      r_an_s1  <= bus.an_n;
      r_an_s2  <= r_an_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Sample interpretation: active-high pattern and one-hot digit select
  // --------------------------------------------------------------------------
  logic [6:0]        w_p;
  logic [DIGITS-1:0] w_an;
  logic              w_sel;
  logic [IDXW-1:0]   w_idx;

  always_comb begin
    w_p   = ~r_seg_s2;
    w_an  = ~r_an_s2;
    // x & (x-1) clears the lowest set bit: zero exactly when one bit is set
    w_sel = (w_an != '0) && ((w_an & (w_an - c_an_one)) == '0);
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_an[i]) w_idx = IDXW'(i);
    end
  end

  function automatic logic [3:0] f_decode(input logic [6:0] p);
    logic [3:0] code;
    case (p)
      7'h3F:   code = 4'h0;
      7'h06:   code = 4'h1;
      7'h5B:   code = 4'h2;
      7'h4F:   code = 4'h3;
      7'h66:   code = 4'h4;
      7'h6D:   code = 4'h5;
      7'h7C:   code = 4'h6;
      7'h27:   code = 4'h7;
      7'h7F:   code = 4'h8;
      7'h67:   code = 4'h9;
      7'h00:   code = c_blank;
      default: code = c_illegal;
    endcase
    return code;
  endfunction

  // --------------------------------------------------------------------------
  // Stability FSM
  // --------------------------------------------------------------------------
  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt,   w_cnt_next;
  logic [IDXW-1:0] r_cur_idx;
  logic [6:0]      r_cur_p;
  logic            w_same;
  logic            w_latch;
  logic            w_commit;

  assign w_same = w_sel && (w_idx == r_cur_idx) && (w_p == r_cur_p);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_sel) begin
          w_latch      = 1'b1;
          w_cnt_next   = c_cnt_one;
          w_state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!w_sel) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else if (w_same) begin
          if (r_cnt == c_cnt_last) begin
            // Counter parks at its last value while holding, so it never
            // runs past STABLE_CYCLES-1.
            w_commit     = 1'b1;
            w_state_next = ST_HOLD;
          end else begin
            w_cnt_next = r_cnt + c_cnt_one;
          end
        end else begin
          // Back-to-back change without a blanking gap starts a new run.
          w_latch    = 1'b1;
          w_cnt_next = c_cnt_one;
        end
      end
      ST_HOLD: begin
        if (!w_sel) begin
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else if (!w_same) begin
          w_latch      = 1'b1;
          w_cnt_next   = c_cnt_one;
          w_state_next = ST_SETTLE;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cur_idx <= '0;
      r_cur_p   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_cur_idx <= w_idx;
        r_cur_p   <= w_p;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Commit: decode, per-position write, pulse generation and frame tracking
  // --------------------------------------------------------------------------
  logic [3:0]        w_cur_code;
  logic              w_legal;
  logic [DIGITS-1:0] w_hit;
  logic [DIGITS-1:0] w_seen_or;
  logic              w_frame;
  logic [DIGITS-1:0] r_seen;
  logic              r_upd, r_err, r_frame;

  always_comb begin
    w_cur_code = f_decode(r_cur_p);
    w_legal    = (w_cur_code != c_illegal);
    w_hit      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_hit[i] = (r_cur_idx == IDXW'(i));
    end
    // Frame completion includes the position being committed right now.
    w_seen_or = r_seen | w_hit;
    w_frame   = w_commit && (w_seen_or == c_all_seen);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd   <= 1'b0;
      r_err   <= 1'b0;
      r_frame <= 1'b0;
      r_seen  <= '0;
    end else begin
      r_upd   <= w_commit;
      r_err   <= w_commit && !w_legal;
      r_frame <= w_frame;
      if (w_commit) begin
        r_seen <= w_frame ? '0 : w_seen_or;
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pos
    logic [3:0] r_code;
    logic       r_ok;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_code <= c_blank;
        r_ok   <= 1'b0;
      end else if (w_commit && w_hit[gi]) begin
        r_code <= w_cur_code;
        r_ok   <= w_legal;
      end
    end

    assign bus.digits[4*gi +: 4] = r_code;
    assign bus.valid[gi]         = r_ok;
  end

  assign bus.upd        = r_upd;
  assign bus.err        = r_err;
  assign bus.frame_done = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_monitor                                              |
// | Description : Self-checking bench for seg7_monitor. A run-length model of |
// |               the capture rules predicts every output each cycle; directed |
// |               sequences and a table sweep cover the listed corner cases.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_monitor;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seg7_monitor_if #(.DIGITS(DIGITS)) bus ();

  seg7_monitor #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_upd    = 0;
  int n_frame  = 0;
  int n_err    = 0;

  logic [6:0] c_pat [10];

  typedef struct {
    logic [6:0] p;
    logic [3:0] exp;
  } vec_t;
  vec_t sweep [11];

  // ---------------------------------------------------------------- model
  logic [6:0]        m_seg1, m_seg2;
  logic [DIGITS-1:0] m_an1,  m_an2;
  bit                m_run_on, m_run_done;
  int                m_run_key, m_run_len;
  logic [3:0]        m_dig [DIGITS];
  bit                m_val [DIGITS];
  bit                m_seen [DIGITS];
  bit                m_upd, m_err, m_frame;

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (p == c_pat[k]) return 4'(k);
    if (p == 7'h00) return 4'hF;
    return 4'hE;
  endfunction

  task automatic model_reset();
    m_seg1 = '1; m_seg2 = '1; m_an1 = '1; m_an2 = '1;
    m_run_on = 0; m_run_done = 0; m_run_key = 0; m_run_len = 0;
    m_upd = 0; m_err = 0; m_frame = 0;
    for (int i = 0; i < DIGITS; i++) begin
      m_dig[i] = 4'hF; m_val[i] = 0; m_seen[i] = 0;
    end
  endtask

  // Called at each rising edge with the pins as they stand at that edge.
  task automatic model_edge();
    logic [6:0]        s;
    logic [DIGITS-1:0] an;
    int                idx, key;
    logic [3:0]        code;
    bit                all;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_upd = 0; m_err = 0; m_frame = 0;
    s  = ~m_seg2;
    an = ~m_an2;
    if ($countones(an) == 1) begin
      idx = 0;
      for (int i = 0; i < DIGITS; i++) if (an[i]) idx = i;
      key = idx * 128 + int'(s);
      if (m_run_on && key == m_run_key) m_run_len++;
      else begin
        m_run_on = 1; m_run_key = key; m_run_len = 1; m_run_done = 0;
      end
      if (m_run_len == STABLE && !m_run_done) begin
        m_run_done = 1;
        code = ref_decode(s);
        m_dig[idx] = code;
        m_val[idx] = (code != 4'hE);
        m_upd = 1;
        m_err = (code == 4'hE);
        m_seen[idx] = 1;
        all = 1;
        for (int i = 0; i < DIGITS; i++) if (!m_seen[i]) all = 0;
        if (all) begin
          m_frame = 1;
          for (int i = 0; i < DIGITS; i++) m_seen[i] = 0;
        end
      end
    end else begin
      m_run_on = 0;
    end
    m_seg2 = m_seg1; m_seg1 = bus.seg_n;
    m_an2  = m_an1;  m_an1  = bus.an_n;
  endtask

  function automatic logic [4*DIGITS-1:0] m_digits();
    logic [4*DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = m_dig[i];
    return v;
  endfunction

  function automatic logic [DIGITS-1:0] m_valid();
    logic [DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i] = m_val[i];
    return v;
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("model_digits", 32'(bus.digits), 32'(m_digits()));
    chk("model_valid",  32'(bus.valid),  32'(m_valid()));
    chk("model_pulses", {29'd0, bus.upd, bus.err, bus.frame_done},
                        {29'd0, m_upd, m_err, m_frame});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
    if (bus.upd)        n_upd++;
    if (bus.frame_done) n_frame++;
    if (bus.err)        n_err++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic show(input int pos, input logic [6:0] p, input int n);
    bus.seg_n = ~p;
    bus.an_n  = ~(DIGITS'(1) << pos);
    steps(n);
  endtask

  task automatic gap(input int n);
    bus.an_n = '1;
    steps(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset_digits", 32'(bus.digits), 32'hFFFF);
    chk("async_reset_valid",  32'(bus.valid),  32'h0);
    steps(3);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int         u0, u1, f0, e0, k;
    bit         saw_one;
    logic [6:0] rp;

    c_pat[0] = 7'h3F; c_pat[1] = 7'h06; c_pat[2] = 7'h5B; c_pat[3] = 7'h4F;
    c_pat[4] = 7'h66; c_pat[5] = 7'h6D; c_pat[6] = 7'h7C; c_pat[7] = 7'h27;
    c_pat[8] = 7'h7F; c_pat[9] = 7'h67;
    for (int i = 0; i < 10; i++) begin
      sweep[i].p   = c_pat[i];
      sweep[i].exp = 4'(i);
    end
    sweep[10].p   = 7'h00;
    sweep[10].exp = 4'hF;

    // Reset with bus activity present
    bus.seg_n = 7'h12;
    bus.an_n  = 4'b0110;
    model_reset();
    steps(3);
    chk("reset_digits", 32'(bus.digits), 32'hFFFF);
    chk("reset_valid",  32'(bus.valid),  32'h0);
    chk("reset_pulses", {29'd0, bus.upd, bus.err, bus.frame_done}, 32'h0);
    rst_n    = 1'b1;
    bus.an_n = 4'b1111;
    steps(6);
    chk("idle_no_upd", n_upd, 0);

    // Single digit with exact latency: first step below is edge E
    bus.seg_n = 7'b1000000;
    bus.an_n  = 4'b1110;
    for (int j = 0; j <= 5; j++) begin
      step();
      chk($sformatf("latency_upd_E+%0d", j), 32'(bus.upd), (j == 5) ? 32'd1 : 32'd0);
    end
    chk("single_digit0", 32'(bus.digits[3:0]), 32'h0);
    chk("single_valid0", 32'(bus.valid[0]), 32'h1);
    steps(50);
    chk("single_one_upd", n_upd, 1);
    gap(4);

    // Table sweep on position 2
    u0 = n_upd;
    for (int i = 0; i < 11; i++) begin
      show(2, sweep[i].p, 10);
      chk($sformatf("sweep_digit_%0d", i), 32'(bus.digits[11:8]), 32'(sweep[i].exp));
      chk($sformatf("sweep_valid_%0d", i), 32'(bus.valid[2]), 32'h1);
    end
    chk("sweep_upd_count", n_upd - u0, 11);
    gap(4);

    // Glitch rejection on position 1
    u0 = n_upd;
    saw_one = 0;
    bus.an_n  = 4'b1101;
    bus.seg_n = ~7'h06;
    for (int j = 0; j < 3; j++) begin
      step();
      if (bus.digits[7:4] == 4'h1) saw_one = 1;
    end
    bus.seg_n = ~7'h5B;
    for (int j = 0; j < 10; j++) begin
      step();
      if (bus.digits[7:4] == 4'h1) saw_one = 1;
    end
    chk("glitch_digit",   32'(bus.digits[7:4]), 32'h2);
    chk("glitch_one_upd", n_upd - u0, 1);
    chk("glitch_no_1",    32'(saw_one), 32'h0);
    gap(4);

    // Illegal pattern on position 3 (bounded wait for the commit)
    e0 = n_err;
    bus.an_n  = 4'b0111;
    bus.seg_n = ~7'h01;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.upd && k < 20);
    chk("illegal_upd_seen", 32'(bus.upd), 32'h1);
    chk("illegal_err_with_upd", 32'(bus.err), 32'h1);
    chk("illegal_digit", 32'(bus.digits[15:12]), 32'hE);
    chk("illegal_valid", 32'(bus.valid[3]), 32'h0);
    steps(5);
    chk("illegal_one_err", n_err - e0, 1);
    gap(4);

    // Two digits enabled at once: never selected
    u0 = n_upd;
    bus.an_n  = 4'b1100;
    bus.seg_n = ~7'h4F;
    steps(20);
    chk("badsel_no_upd", n_upd - u0, 0);
    gap(4);

    // Scan "1234": 8-cycle dwell, 2-cycle gap
    for (int s = 0; s < 3; s++) begin
      u0 = n_upd; f0 = n_frame;
      for (int p = 0; p < 4; p++) begin
        show(p, c_pat[p + 1], 8);
        gap(2);
      end
      chk($sformatf("scan%0d_digits", s), 32'(bus.digits), 32'h4321);
      chk($sformatf("scan%0d_valid",  s), 32'(bus.valid),  32'hF);
      chk($sformatf("scan%0d_upd",    s), n_upd - u0, 4);
      chk($sformatf("scan%0d_frame",  s), n_frame - f0, 1);
    end

    // Reset mid-scan: the partial seen mask must be discarded
    show(0, c_pat[1], 8); gap(2);
    show(1, c_pat[2], 8); gap(2);
    show(2, c_pat[3], 4);
    do_reset();
    f0 = n_frame; u1 = n_upd;
    show(2, c_pat[3], 8); gap(2);
    show(3, c_pat[4], 8); gap(2);
    chk("rst_scan_no_frame_yet", n_frame - f0, 0);
    show(0, c_pat[1], 8); gap(2);
    chk("rst_scan_still_no_frame", n_frame - f0, 0);
    show(1, c_pat[2], 8); gap(2);
    chk("rst_scan_frame_after_4", n_frame - f0, 1);
    chk("rst_scan_upd_count", n_upd - u1, 4);
    chk("rst_scan_digits", 32'(bus.digits), 32'h4321);

    // Randomized traffic against the model
    for (int r = 0; r < 300; r++) begin
      k = $urandom_range(0, 9);
      if (k < 7)       bus.an_n = ~(DIGITS'(1) << $urandom_range(0, DIGITS - 1));
      else if (k == 7) bus.an_n = '1;
      else             bus.an_n = DIGITS'($urandom);
      k = $urandom_range(0, 9);
      if (k < 7)       rp = c_pat[$urandom_range(0, 9)];
      else if (k == 7) rp = 7'h00;
      else             rp = 7'($urandom);
      bus.seg_n = ~rp;
      steps($urandom_range(1, 9));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
